// File: rtl/rv32i_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_exec_unit
// Purpose  : Single-cycle RV32I execute slice: combinational main/ALU
//            decoder, 32-bit ALU, and a word-organised data memory with a
//            preload (init) write port and a combinational debug read port.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            clock, synchronous active-high reset
//   opcode/func3/func7  instruction fields
//   rs1_data, rs2_data  register operands (rs2 is also store data)
//   imm                 sign-extended immediate
//   init_done           0: memory write port owned by init_*, 1: by datapath
//   init_addr/dat/wen   preload write port (byte address)
//   debug_addr          debug read byte address
//   branch              PC select (take imm-relative target)
//   imm_src             immediate format I=0 S=1 B=2 J=3 U=4
//   alu_ctrl            ALU operation select
//   alu_src             0: B = rs2_data, 1: B = imm
//   reg_write           register-file write enable
//   wrt_back_src        0: memory, 1: ALU, 2: PC+4
//   mem_read, mem_write data-memory enables
//   alu_result          ALU result / memory byte address
//   alu_zero            alu_result == 0
//   mem_rdata           read data (0 when mem_read is low)
//   debug_data          word at debug_addr
// ============================================================================
module rv32i_exec_unit #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       rs2_data,
  input  logic [31:0]       imm,
  input  logic              init_done,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_dat,
  input  logic              init_wen,
  input  logic [ADDR_W-1:0] debug_addr,
  output logic              branch,
  output logic [2:0]        imm_src,
  output logic [3:0]        alu_ctrl,
  output logic              alu_src,
  output logic              reg_write,
  output logic [1:0]        wrt_back_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       alu_result,
  output logic              alu_zero,
  output logic [31:0]       mem_rdata,
  output logic [31:0]       debug_data
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  localparam logic [6:0] c_F7_BASE   = 7'b0000000;
  localparam logic [6:0] c_F7_ALT    = 7'b0100000;

  localparam logic [2:0] c_IMM_I = 3'd0;
  localparam logic [2:0] c_IMM_S = 3'd1;
  localparam logic [2:0] c_IMM_B = 3'd2;
  localparam logic [2:0] c_IMM_J = 3'd3;

  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_AND  = 4'd2;
  localparam logic [3:0] c_ALU_OR   = 4'd3;
  localparam logic [3:0] c_ALU_XOR  = 4'd4;
  localparam logic [3:0] c_ALU_SLL  = 4'd5;
  localparam logic [3:0] c_ALU_SRL  = 4'd6;
  localparam logic [3:0] c_ALU_SRA  = 4'd7;
  localparam logic [3:0] c_ALU_SLT  = 4'd8;
  localparam logic [3:0] c_ALU_SLTU = 4'd9;

  localparam logic [1:0] c_WB_MEM = 2'd0;
  localparam logic [1:0] c_WB_ALU = 2'd1;
  localparam logic [1:0] c_WB_PC4 = 2'd2;

  localparam int c_IDX_W = ADDR_W - 2;

  // Shared func3 -> ALU op table for R-type and I-ALU. 'alt' (func7[5]) only
  // picks SUB/SRA; callers pass 0 for the ADD slot of I-ALU (no SUBI).
  function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_alu = alt ? c_ALU_SUB : c_ALU_ADD;
      3'b001:  f3_alu = c_ALU_SLL;
      3'b010:  f3_alu = c_ALU_SLT;
      3'b011:  f3_alu = c_ALU_SLTU;
      3'b100:  f3_alu = c_ALU_XOR;
      3'b101:  f3_alu = alt ? c_ALU_SRA : c_ALU_SRL;
      3'b110:  f3_alu = c_ALU_OR;
      default: f3_alu = c_ALU_AND;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Main decoder. Branch resolution is split out below so the decoder does
  // not feed back on alu_zero within a single process.
  // --------------------------------------------------------------------------
  logic w_f7_base;
  logic w_f7_alt;
  logic w_is_branch;   // conditional branch instruction decoded
  logic w_br_invert;   // 1: take when result non-zero, 0: take when zero
  logic w_is_jump;     // unconditional (JAL)

  assign w_f7_base = (func7 == c_F7_BASE);
  assign w_f7_alt  = (func7 == c_F7_ALT);

  always_comb begin
    imm_src      = c_IMM_I;
    alu_ctrl     = c_ALU_ADD;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    wrt_back_src = c_WB_MEM;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    w_is_branch  = 1'b0;
    w_br_invert  = 1'b0;
    w_is_jump    = 1'b0;

    if (!rst) begin
      case (opcode)
        c_OP_R: begin
          // func7 must be all-zero, or 0100000 for the SUB/SRA slots only
          if (w_f7_base || (w_f7_alt && (func3 == 3'b000 || func3 == 3'b101))) begin
            alu_ctrl     = f3_alu(func3, w_f7_alt);
            reg_write    = 1'b1;
            wrt_back_src = c_WB_ALU;
          end
        end

        c_OP_I: begin
          // func7 is immediate data except for the shift-immediate forms
          if ((func3 != 3'b001 && func3 != 3'b101) ||
              (func3 == 3'b001 && w_f7_base) ||
              (func3 == 3'b101 && (w_f7_base || w_f7_alt))) begin
            alu_ctrl     = f3_alu(func3, (func3 == 3'b101) && w_f7_alt);
            alu_src      = 1'b1;
            imm_src      = c_IMM_I;
            reg_write    = 1'b1;
            wrt_back_src = c_WB_ALU;
          end
        end

        c_OP_LOAD: begin
          if (func3 == 3'b010) begin
            alu_ctrl     = c_ALU_ADD;
            alu_src      = 1'b1;
            imm_src      = c_IMM_I;
            mem_read     = 1'b1;
            reg_write    = 1'b1;
            wrt_back_src = c_WB_MEM;
          end
        end

        c_OP_STORE: begin
          if (func3 == 3'b010) begin
            alu_ctrl  = c_ALU_ADD;
            alu_src   = 1'b1;
            imm_src   = c_IMM_S;
            mem_write = 1'b1;
          end
        end

        c_OP_BRANCH: begin
          case (func3)
            3'b000: begin alu_ctrl = c_ALU_SUB;  w_is_branch = 1'b1; w_br_invert = 1'b0; end
            3'b001: begin alu_ctrl = c_ALU_SUB;  w_is_branch = 1'b1; w_br_invert = 1'b1; end
            3'b100: begin alu_ctrl = c_ALU_SLT;  w_is_branch = 1'b1; w_br_invert = 1'b1; end
            3'b101: begin alu_ctrl = c_ALU_SLT;  w_is_branch = 1'b1; w_br_invert = 1'b0; end
            3'b110: begin alu_ctrl = c_ALU_SLTU; w_is_branch = 1'b1; w_br_invert = 1'b1; end
            3'b111: begin alu_ctrl = c_ALU_SLTU; w_is_branch = 1'b1; w_br_invert = 1'b0; end
            default: ;
          endcase
          if (w_is_branch) begin
            imm_src = c_IMM_B;
            alu_src = 1'b0;
          end
        end

        c_OP_JAL: begin
          w_is_jump    = 1'b1;
          imm_src      = c_IMM_J;
          reg_write    = 1'b1;
          wrt_back_src = c_WB_PC4;
        end

        default: ;
      endcase
    end
  end

  // Branch decision uses the ALU flag produced from this cycle's operands.
  assign branch = w_is_jump | (w_is_branch & (alu_zero ^ w_br_invert));

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [31:0] w_op_b;

  assign w_op_b = alu_src ? imm : rs2_data;

  always_comb begin
    alu_result = 32'd0;
    case (alu_ctrl)
      c_ALU_ADD:  alu_result = rs1_data + w_op_b;
      c_ALU_SUB:  alu_result = rs1_data - w_op_b;
      c_ALU_AND:  alu_result = rs1_data & w_op_b;
      c_ALU_OR:   alu_result = rs1_data | w_op_b;
      c_ALU_XOR:  alu_result = rs1_data ^ w_op_b;
      c_ALU_SLL:  alu_result = rs1_data << w_op_b[4:0];
      c_ALU_SRL:  alu_result = rs1_data >> w_op_b[4:0];
      c_ALU_SRA:  alu_result = $unsigned($signed(rs1_data) >>> w_op_b[4:0]);
      c_ALU_SLT:  alu_result = {31'd0, $signed(rs1_data) < $signed(w_op_b)};
      c_ALU_SLTU: alu_result = {31'd0, rs1_data < w_op_b};
      default:    alu_result = 32'd0;
    endcase
  end

  assign alu_zero = (alu_result == 32'd0);

  // --------------------------------------------------------------------------
  // Data memory: one write port muxed between preload and datapath, a
  // datapath read port and a debug read port. Byte address bits [1:0] are
  // dropped; word indices beyond DEPTH are ignored on write and read as 0.
  // --------------------------------------------------------------------------
  logic [31:0]        r_mem [DEPTH];
  logic [c_IDX_W-1:0] w_wr_idx;
  logic [31:0]        w_wr_dat;
  logic               w_wr_en;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic [c_IDX_W-1:0] w_dbg_idx;

  assign w_wr_idx  = init_done ? alu_result[ADDR_W-1:2] : init_addr[ADDR_W-1:2];
  assign w_wr_dat  = init_done ? rs2_data : init_dat;
  assign w_wr_en   = init_done ? mem_write : init_wen;
  assign w_rd_idx  = alu_result[ADDR_W-1:2];
  assign w_dbg_idx = debug_addr[ADDR_W-1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_wr_en && (32'(w_wr_idx) < DEPTH)) begin
      r_mem[w_wr_idx] <= w_wr_dat;
    end
  end

  // Reads are asynchronous: a store in flight is visible only after the edge.
  assign mem_rdata  = (mem_read && !rst && (32'(w_rd_idx) < DEPTH)) ? r_mem[w_rd_idx] : 32'd0;
  assign debug_data = (32'(w_dbg_idx) < DEPTH) ? r_mem[w_dbg_idx] : 32'd0;

  // Address bits that never select a word.
  logic w_unused;
  assign w_unused = ^{alu_result[31:ADDR_W], alu_result[1:0],
                      init_addr[1:0], debug_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_rv32i_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_exec_unit
// Purpose  : Directed self-checking bench for rv32i_exec_unit. Inputs are
//            driven 1 time unit after the rising edge and outputs are
//            checked 1 unit later, well clear of the next edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_rv32i_exec_unit;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 256;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  logic              clk;
  logic              rst;
  logic [6:0]        opcode;
  logic [2:0]        func3;
  logic [6:0]        func7;
  logic [31:0]       rs1_data;
  logic [31:0]       rs2_data;
  logic [31:0]       imm;
  logic              init_done;
  logic [ADDR_W-1:0] init_addr;
  logic [31:0]       init_dat;
  logic              init_wen;
  logic [ADDR_W-1:0] debug_addr;
  logic              branch;
  logic [2:0]        imm_src;
  logic [3:0]        alu_ctrl;
  logic              alu_src;
  logic              reg_write;
  logic [1:0]        wrt_back_src;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       alu_result;
  logic              alu_zero;
  logic [31:0]       mem_rdata;
  logic [31:0]       debug_data;

  int vectors;
  int miscompares;

  rv32i_exec_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .func3        (func3),
    .func7        (func7),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .init_done    (init_done),
    .init_addr    (init_addr),
    .init_dat     (init_dat),
    .init_wen     (init_wen),
    .debug_addr   (debug_addr),
    .branch       (branch),
    .imm_src      (imm_src),
    .alu_ctrl     (alu_ctrl),
    .alu_src      (alu_src),
    .reg_write    (reg_write),
    .wrt_back_src (wrt_back_src),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .mem_rdata    (mem_rdata),
    .debug_data   (debug_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    opcode   = op;
    func3    = f3;
    func7    = f7;
    rs1_data = a;
    rs2_data = b;
    imm      = im;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    init_done   = 1'b0;
    init_addr   = '0;
    init_dat    = '0;
    init_wen    = 1'b0;
    debug_addr  = '0;

    // Reset: decoded R-type must still yield all-zero control
    instr(c_OP_R, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_wb_src", 32'(wrt_back_src), 32'd0);
    tick();
    rst = 1'b0;

    // Preload word 0x00C via the init port
    init_wen  = 1'b1;
    init_addr = 10'h00C;
    init_dat  = 32'd6;
    tick();
    init_wen   = 1'b0;
    debug_addr = 10'h00C;
    #1;
    chk("init_debug", debug_data, 32'h6);
    debug_addr = 10'h00E;   // low byte bits ignored
    #1;
    chk("init_debug_lowbits", debug_data, 32'h6);

    init_done = 1'b1;

    // beq taken / not taken
    instr(c_OP_BRANCH, 3'b000, 7'd0, 32'd3, 32'd3, 32'd0);
    chk("beq_alu_ctrl", 32'(alu_ctrl), 32'd1);
    chk("beq_result", alu_result, 32'd0);
    chk("beq_zero", 32'(alu_zero), 32'd1);
    chk("beq_branch", 32'(branch), 32'd1);
    chk("beq_imm_src", 32'(imm_src), 32'd2);
    chk("beq_reg_write", 32'(reg_write), 32'd0);
    instr(c_OP_BRANCH, 3'b000, 7'd0, 32'd3, 32'd6, 32'd0);
    chk("beq_nt_branch", 32'(branch), 32'd0);

    // bne taken / not taken
    instr(c_OP_BRANCH, 3'b001, 7'd0, 32'd6, 32'd7, 32'd0);
    chk("bne_branch", 32'(branch), 32'd1);
    instr(c_OP_BRANCH, 3'b001, 7'd0, 32'd6, 32'd6, 32'd0);
    chk("bne_nt_branch", 32'(branch), 32'd0);

    // Signed vs unsigned compare on -1 < 1
    instr(c_OP_BRANCH, 3'b100, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("blt_ctrl", 32'(alu_ctrl), 32'd8);
    chk("blt_branch", 32'(branch), 32'd1);
    instr(c_OP_BRANCH, 3'b110, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("bltu_branch", 32'(branch), 32'd0);
    instr(c_OP_BRANCH, 3'b111, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("bgeu_branch", 32'(branch), 32'd1);
    instr(c_OP_BRANCH, 3'b010, 7'd0, 32'd3, 32'd3, 32'd0);
    chk("bad_branch_f3", 32'(branch), 32'd0);

    // lw from preloaded word
    instr(c_OP_LOAD, 3'b010, 7'd0, 32'd8, 32'd0, 32'd4);
    chk("lw_addr", alu_result, 32'h0000_000C);
    chk("lw_mem_read", 32'(mem_read), 32'd1);
    chk("lw_rdata", mem_rdata, 32'd6);
    chk("lw_wb_src", 32'(wrt_back_src), 32'd0);
    chk("lw_reg_write", 32'(reg_write), 32'd1);
    instr(c_OP_LOAD, 3'b000, 7'd0, 32'd8, 32'd0, 32'd4);
    chk("lb_undecoded_rdata", mem_rdata, 32'd0);

    // sw: old value visible until the edge, new value after
    instr(c_OP_STORE, 3'b010, 7'd0, 32'd0, 32'hAB, 32'h10);
    debug_addr = 10'h010;
    #1;
    chk("sw_mem_write", 32'(mem_write), 32'd1);
    chk("sw_imm_src", 32'(imm_src), 32'd1);
    chk("sw_rdata_idle", mem_rdata, 32'd0);
    chk("sw_pre_edge", debug_data, 32'd0);
    tick();
    opcode = 7'd0;
    #1;
    chk("sw_post_edge", debug_data, 32'hAB);

    // R-type
    instr(c_OP_R, 3'b000, 7'b0100000, 32'd5, 32'd3, 32'd0);
    chk("sub_result", alu_result, 32'd2);
    chk("sub_wb_src", 32'(wrt_back_src), 32'd1);
    instr(c_OP_R, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'd0);
    chk("sra_result", alu_result, 32'hF800_0000);
    instr(c_OP_R, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4, 32'd0);
    chk("srl_result", alu_result, 32'h0800_0000);
    instr(c_OP_R, 3'b001, 7'b0000000, 32'd1, 32'h21, 32'd0);
    chk("sll_b40", alu_result, 32'd2);
    instr(c_OP_R, 3'b011, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd0);
    chk("sltu_result", alu_result, 32'd1);
    instr(c_OP_R, 3'b100, 7'b0000000, 32'hF0F0_1234, 32'h0FF0_1234, 32'd0);
    chk("xor_result", alu_result, 32'hFF00_0000);

    // I-ALU: addi wrap, no SUBI, srai
    instr(c_OP_I, 3'b000, 7'b0100000, 32'hFFFF_FFFF, 32'd9, 32'd1);
    chk("addi_wrap", alu_result, 32'd0);
    chk("addi_zero", 32'(alu_zero), 32'd1);
    chk("addi_alu_src", 32'(alu_src), 32'd1);
    instr(c_OP_I, 3'b101, 7'b0100000, 32'hFFFF_FF00, 32'd0, 32'h404);
    chk("srai_result", alu_result, 32'hFFFF_FFF0);

    // JAL
    instr(c_OP_JAL, 3'b000, 7'd0, 32'd0, 32'd0, 32'd0);
    chk("jal_branch", 32'(branch), 32'd1);
    chk("jal_imm_src", 32'(imm_src), 32'd3);
    chk("jal_wb_src", 32'(wrt_back_src), 32'd2);

    // Undecoded opcode
    instr(7'b1111111, 3'b000, 7'b0100000, 32'd1, 32'd1, 32'd1);
    chk("undec_ctrl", {branch, imm_src, alu_ctrl, alu_src, reg_write, wrt_back_src, mem_read, mem_write},
        32'd0);

    // Reset during a store: no write, outputs forced, memory cleared
    instr(c_OP_STORE, 3'b010, 7'd0, 32'd0, 32'h55, 32'h14);
    rst = 1'b1;
    #1;
    chk("rst_store_branch", 32'(branch), 32'd0);
    chk("rst_store_mem_write", 32'(mem_write), 32'd0);
    chk("rst_store_rdata", mem_rdata, 32'd0);
    tick();
    rst    = 1'b0;
    opcode = 7'd0;
    debug_addr = 10'h014;
    #1;
    chk("rst_no_write", debug_data, 32'd0);
    debug_addr = 10'h00C;
    #1;
    chk("rst_clear_0c", debug_data, 32'd0);
    debug_addr = 10'h010;
    #1;
    chk("rst_clear_10", debug_data, 32'd0);
    instr(c_OP_LOAD, 3'b010, 7'd0, 32'd8, 32'd0, 32'd4);
    chk("rst_lw_rdata", mem_rdata, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32i_exec_unit.md
RV32I_EXEC_UNIT -- requirements
Module: rv32i_exec_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width of the data memory.
REQ-002 SHALL have parameter DEPTH, default 256, 32-bit word count (byte addr[ADDR_W-1:2] indexes a word).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 opcode  in  7  instruction[6:0].
REQ-006 func3  in  3  instruction[14:12].
REQ-007 func7  in  7  instruction[31:25].
REQ-008 rs1_data  in  32  register-file rs1 value.
REQ-009 rs2_data  in  32  register-file rs2 value; also store data.
REQ-010 imm  in  32  sign-extended immediate.
REQ-011 init_done  in  1  0: memory write port driven by init_*; 1: driven by datapath.
REQ-012 init_addr  in  ADDR_W  preload byte address.
REQ-013 init_dat  in  32  preload data.
REQ-014 init_wen  in  1  preload write enable.
REQ-015 debug_addr  in  ADDR_W  debug read byte address.
REQ-016 branch  out  1  PC select: take imm-relative target.
REQ-017 imm_src  out  3  immediate format: I=0, S=1, B=2, J=3, U=4.
REQ-018 alu_ctrl  out  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
REQ-019 alu_src  out  1  0: operand B = rs2_data; 1: operand B = imm.
REQ-020 reg_write  out  1  register-file write enable.
REQ-021 wrt_back_src  out  2  MEMORY_READ=0, ALU_RESULTS=1, PC_PLUS_4=2.
REQ-022 mem_read  out  1  data-memory read enable.
REQ-023 mem_write  out  1  data-memory write enable.
REQ-024 alu_result  out  32  ALU result; also memory byte address.
REQ-025 alu_zero  out  1  alu_result == 0.
REQ-026 mem_rdata  out  32  data-memory read data.
REQ-027 debug_data  out  32  word at debug_addr, combinational, independent of mem_read.

Function
REQ-028 Control SHALL be combinational; any undecoded opcode/func drives all control outputs 0 (alu_ctrl ADD).
REQ-029 R-type 0110011: alu_src=0, reg_write=1, wb=ALU; func3/func7[5] select ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
REQ-030 I-ALU 0010011: alu_src=1, imm_src=I, reg_write=1, wb=ALU; func7[5] selects SRA for func3=101; no SUBI.
REQ-031 Load 0000011 (func3=010): ADD, alu_src=1, imm_src=I, mem_read=1, reg_write=1, wb=MEMORY_READ.
REQ-032 Store 0100011 (func3=010): ADD, alu_src=1, imm_src=S, mem_write=1, reg_write=0.
REQ-033 Branch 1100011: alu_src=0, imm_src=B, reg_write=0; beq: SUB, branch=zero; bne: SUB, branch=!zero; blt/bge: SLT, branch=!zero/zero; bltu/bgeu: SLTU, branch=!zero/zero.
REQ-034 JAL 1101111: branch=1, imm_src=J, reg_write=1, wb=PC_PLUS_4.
REQ-035 ALU SHALL be combinational, 32-bit wrap-around add/sub; shifts use operand B[4:0]; SLT signed, SLTU unsigned, result 0/1.
REQ-036 Memory write SHALL occur on rising edge when selected enable is 1, word at addr[ADDR_W-1:2]; addr[1:0] ignored.
REQ-037 mem_rdata SHALL be combinational: word at alu_result[ADDR_W-1:2] when mem_read=1, else 0; read-during-write returns old word until the edge.

Reset
REQ-038 While rst=1: control outputs forced 0, mem_rdata=0, memory writes suppressed; on the edge with rst=1 all words clear to 0.

Verification
REQ-039 init_done=0, init_wen=1, init_addr=0x00C, init_dat=6, one edge; debug_addr=0x00C -> debug_data=0x00000006.
REQ-040 beq (func3=000), rs1=3, rs2=3 -> alu_ctrl=1, alu_result=0, alu_zero=1, branch=1, imm_src=2, reg_write=0; rs2=6 -> branch=0.
REQ-041 bne (func3=001), rs1=6, rs2=7 -> branch=1; rs2=6 -> branch=0.
REQ-042 lw, init_done=1, rs1=8, imm=4, mem[0xC]=6 -> alu_result=0xC, mem_read=1, mem_rdata=6, wrt_back_src=0, reg_write=1.
REQ-043 sw, rs1=0, imm=0x10, rs2=0xAB, one edge -> debug_data at 0x010 = 0xAB; R-type SUB (func7=0100000) 5-3 -> alu_result=2.
REQ-044 rst=1 during a store -> no write, branch=0, mem_write=0, mem_rdata=0; all words read 0 afterwards.
